// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the 8N1 UART receive path.
package uart_rx_pkg;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with simultaneous push/pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver: synchronizer, start-edge detect, mid-bit sampling FSM
// and a FWFT byte buffer for the downstream consumer.
module uart_rx_monitor
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(DATA_BITS);

    logic                   sync_p0;
    logic                   sync_p1;
    logic                   prev_p2;
    logic [SYNC_STAGES-1:0] fill;
    logic                   fall;

    rx_state_t              state;
    logic [CNT_W-1:0]       cnt;
    logic                   expire;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shreg;

    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_head;

    // Synchronizer and edge register. The edge register only holds a 1 once
    // the synchronizer carries real line data, so a line already low out of
    // reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b0;
            fill    <= '0;
        end else begin
            sync_p0 <= rxd;
            sync_p1 <= sync_p0;
            fill    <= {fill[SYNC_STAGES-2:0], 1'b1};
            prev_p2 <= sync_p1 & fill[SYNC_STAGES-1];
        end
    end

    assign fall   = prev_p2 & ~sync_p1;
    assign expire = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                        cnt   <= CNT_W'(HALF - 1);
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (!expire) begin
                        cnt <= cnt - 1'b1;
                    end else if (!sync_p1) begin
                        state   <= DATA;
                        cnt     <= CNT_W'(DIV - 1);
                        bit_idx <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                DATA: begin
                    if (!expire) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt     <= CNT_W'(DIV - 1);
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (!expire) begin
                        cnt <= cnt - 1'b1;
                    end else if (sync_p1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state     <= WAIT_IDLE;
                        frame_err <= 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (sync_p1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && expire) begin
            shreg <= {sync_p1, shreg[DATA_BITS-1:1]};
        end
    end

    // Push on the stop sample itself so the byte lands on the same edge that
    // would raise frame_err or overrun.
    assign push = (state == STOP) & expire & sync_p1;
    assign pop  = rx_valid & rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else begin
            overrun <= push & fifo_full & ~pop;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (shreg),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rx_valid = ~fifo_empty;
    assign rx_data  = rx_valid ? fifo_head : '0;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor at 10 clocks per bit.
module tb_uart_rx_monitor;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [4:0] fifo_count;

    int errors = 0;
    int checks = 0;

    int fe_cnt = 0;
    int ov_cnt = 0;
    int busy_cycles = 0;
    logic [7:0] pop_q [$];

    uart_rx_monitor #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe once per cycle, just after inputs settle on the falling edge.
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (busy) busy_cycles++;
            if (rx_valid && rx_ready) pop_q.push_back(rx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk);
        rxd = v;
        repeat (9) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_count"}, fifo_count, 0);
        check({tag, "_ferr"}, frame_err, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_data"}, rx_data, 8'h00);
    endtask

    initial begin
        int fe0, ov0, bz0, q0;
        logic [7:0] expb;

        reset    = 1'b1;
        rxd      = 1'b0;
        rx_ready = 1'b0;

        // Line held low through reset must not start a frame.
        wait_cycles(4);
        reset = 1'b0;
        bz0 = busy_cycles;
        wait_cycles(30);
        check("low_after_reset_busy", busy_cycles - bz0, 0);
        rxd = 1'b1;
        wait_cycles(20);
        check("low_after_reset_count", fifo_count, 0);

        do_reset();
        wait_cycles(1);
        check_reset_outputs("reset");
        wait_cycles(10);

        // Single byte with consumer stalled.
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'hA5, 1'b1);
        wait_cycles(3);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_count", fifo_count, 1);
        check("a5_no_ferr", fe_cnt - fe0, 0);
        check("a5_no_ovr", ov_cnt - ov0, 0);
        q0 = pop_q.size();
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
        wait_cycles(2);
        check("a5_pop_n", pop_q.size() - q0, 1);
        if (pop_q.size() > q0) check("a5_pop_data", pop_q[q0], 8'hA5);
        check("a5_pop_count", fifo_count, 0);

        // Back-to-back frames with no idle time, consumer always ready.
        q0 = pop_q.size();
        rx_ready = 1'b1;
        send_frame(8'h55, 1'b1);
        send_frame(8'hC3, 1'b1);
        wait_cycles(5);
        rx_ready = 1'b0;
        check("b2b_pop_n", pop_q.size() - q0, 2);
        if (pop_q.size() >= q0 + 2) begin
            check("b2b_first", pop_q[q0], 8'h55);
            check("b2b_second", pop_q[q0+1], 8'hC3);
        end
        check("b2b_count", fifo_count, 0);
        wait_cycles(10);

        // 3-cycle glitch: START is entered for HALF cycles then abandoned.
        fe0 = fe_cnt; bz0 = busy_cycles;
        @(negedge clk);
        rxd = 1'b0;
        wait_cycles(3);
        rxd = 1'b1;
        wait_cycles(20);
        check("glitch_busy_cycles", busy_cycles - bz0, 5);
        check("glitch_busy", busy, 0);
        check("glitch_count", fifo_count, 0);
        check("glitch_ferr", fe_cnt - fe0, 0);

        // Low stop bit followed by a 50-cycle break.
        fe0 = fe_cnt;
        send_frame(8'h12, 1'b0);
        wait_cycles(50);
        check("break_busy_held", busy, 1);
        rxd = 1'b1;
        wait_cycles(20);
        check("break_ferr_once", fe_cnt - fe0, 1);
        check("break_busy_clear", busy, 0);
        check("break_count", fifo_count, 0);
        wait_cycles(10);

        // 17 frames into a 16-deep FIFO.
        ov0 = ov_cnt;
        for (int i = 0; i < 17; i++) send_frame(8'(8'h30 + i), 1'b1);
        wait_cycles(3);
        check("ovr_count_full", fifo_count, 16);
        check("ovr_pulses", ov_cnt - ov0, 1);
        q0 = pop_q.size();
        rx_ready = 1'b1;
        wait_cycles(20);
        rx_ready = 1'b0;
        check("ovr_pop_n", pop_q.size() - q0, 16);
        if (pop_q.size() >= q0 + 16) begin
            for (int i = 0; i < 16; i++) begin
                expb = 8'(8'h30 + i);
                check($sformatf("ovr_order_%0d", i), pop_q[q0+i], expb);
            end
        end
        check("ovr_count_empty", fifo_count, 0);
        wait_cycles(10);

        // Reset during DATA bit 4 with one byte already buffered.
        send_frame(8'h3C, 1'b1);
        wait_cycles(3);
        check("pre_reset_count", fifo_count, 1);
        fe0 = fe_cnt; ov0 = ov_cnt;
        for (int i = 0; i < 5; i++) drive_bit(1'b0);
        wait_cycles(6);
        check("mid_frame_busy", busy, 1);
        rxd = 1'b1;
        do_reset();
        wait_cycles(1);
        check_reset_outputs("midreset");
        wait_cycles(15);
        send_frame(8'h7E, 1'b1);
        wait_cycles(3);
        check("post_reset_valid", rx_valid, 1);
        check("post_reset_data", rx_data, 8'h7E);
        check("post_reset_count", fifo_count, 1);
        check("post_reset_ferr", fe_cnt - fe0, 0);
        check("post_reset_ovr", ov_cnt - ov0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
